mpi_rx_responder: RTL

Synthesizable receive-side endpoint of the MPI rendezvous protocol: answers a sender's sync envelope with clear-to-send, streams the data-packet payload to the user kernel, and closes the transfer with data-transmission-done. Sits between the network bridge and a user kernel. The bridge strips and inserts the L2/L3 header, so both MPI streams here start directly at the 64-bit MPI header word.

---
 rtl/mpi_rx_responder_if.sv | 53 +++++
 rtl/mpi_rx_responder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpi_rx_responder_if.sv
// Stream and request/completion bundle for the MPI rendezvous receive endpoint.
// slave = responder side, master = bridge/kernel/host side.
interface mpi_rx_responder_if;
    logic [7:0]  my_rank;
    logic        recv_req_valid;
    logic        recv_req_ready;
    logic [7:0]  recv_req_src;
    logic [15:0] recv_req_size;
    logic        recv_done_valid;
    logic        recv_done_status;
    logic [15:0] recv_done_beats;

    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;

    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic [7:0]  m_tdest;
    logic        m_tready;

    logic [63:0] p_tdata;
    logic [7:0]  p_tkeep;
    logic        p_tlast;
    logic        p_tvalid;
    logic        p_tready;

    modport slave (
        input  my_rank, recv_req_valid, recv_req_src, recv_req_size,
        output recv_req_ready, recv_done_valid, recv_done_status, recv_done_beats,
        input  s_tdata, s_tkeep, s_tlast, s_tvalid,
        output s_tready,
        output m_tdata, m_tkeep, m_tlast, m_tvalid, m_tdest,
        input  m_tready,
        output p_tdata, p_tkeep, p_tlast, p_tvalid,
        input  p_tready
    );

    modport master (
        output my_rank, recv_req_valid, recv_req_src, recv_req_size,
        input  recv_req_ready, recv_done_valid, recv_done_status, recv_done_beats,
        output s_tdata, s_tkeep, s_tlast, s_tvalid,
        input  s_tready,
        input  m_tdata, m_tkeep, m_tlast, m_tvalid, m_tdest,
        output m_tready,
        input  p_tdata, p_tkeep, p_tlast, p_tvalid,
        output p_tready
    );
endinterface

// File: rtl/mpi_rx_responder.sv
// MPI rendezvous receive endpoint: envelope -> CLR2SND, payload passthrough, DONE.
// Optional MPI_RX_SIZE_CHECK_EN answers oversize envelopes with RECV_ERROR.
//
// state     | meaning
// IDLE      | waiting for a posted receive
// WAIT_ENV  | looking for the sync envelope from peer
// ENV_TAIL  | consuming the rest of the envelope packet
// CTS_HDR   | CLR2SND header beat on m
// CTS_TAIL  | CLR2SND trailer beat on m
// WAIT_DATA | looking for the DATA header from peer
// PAYLOAD   | s -> p passthrough, counting beats
// DONE_HDR  | DONE header beat on m
// DONE_TAIL | DONE trailer beat on m
// ERR_HDR   | RECV_ERROR header beat on m
// ERR_TAIL  | RECV_ERROR trailer beat on m
// DROP      | discarding a foreign packet, then back to ret_state
module mpi_rx_responder (
    input  logic clk,
    input  logic aresetn,
    mpi_rx_responder_if.slave bus
);
    localparam logic [7:0] T_SYNC_ENV   = 8'd0;
    localparam logic [7:0] T_CLR2SND    = 8'd1;
    localparam logic [7:0] T_DATA       = 8'd2;
    localparam logic [7:0] T_RECV_ERROR = 8'd4;
    localparam logic [7:0] T_DONE       = 8'd5;

    typedef enum logic [3:0] {
        IDLE, WAIT_ENV, ENV_TAIL, CTS_HDR, CTS_TAIL, WAIT_DATA,
        PAYLOAD, DONE_HDR, DONE_TAIL, ERR_HDR, ERR_TAIL, DROP
    } state_t;

    state_t      state, state_nxt;
    state_t      ret_state, ret_state_nxt;

    logic [7:0]  peer;
    logic [15:0] max_size;
    logic [15:0] env_size;
    logic [15:0] beat_cnt;
    logic        size_err;
    logic        hdr_next;
    logic        rst_done;

    logic        m_tvalid_q;
    logic [63:0] m_tdata_q;
    logic        m_tlast_q;
    logic        done_valid_q;
    logic        done_status_q;
    logic [15:0] done_beats_q;

    logic        s_tready;
    logic        p_tvalid;
    logic        req_ready;
    logic        req_hs;
    logic        m_hs;
    logic        s_hs;

    logic        latch_req;
    logic        latch_env;
    logic        beat_inc;
    logic        done_fire;
    logic        done_err;
    logic        m_load;
    logic        m_tail;
    logic [7:0]  m_type;
    logic [15:0] m_size;

    logic [15:0] hdr_dst;
    logic [7:0]  hdr_src;
    logic [7:0]  hdr_type;
    logic [15:0] hdr_size;
    logic        from_peer;
    logic        env_match;
    logic        data_match;
    logic        env_oversize;

    assign hdr_dst  = bus.s_tdata[15:0];
    assign hdr_src  = bus.s_tdata[23:16];
    assign hdr_type = bus.s_tdata[31:24];
    assign hdr_size = bus.s_tdata[47:32];

    assign from_peer  = hdr_next && (hdr_src == peer) && (hdr_dst == {8'h00, bus.my_rank});
    assign env_match  = from_peer && (hdr_type == T_SYNC_ENV);
    assign data_match = from_peer && (hdr_type == T_DATA);

`ifdef MPI_RX_SIZE_CHECK_EN
    assign env_oversize = (hdr_size > max_size);
`else
    assign env_oversize = 1'b0;
`endif

    // Ready is held off for one cycle after reset so it reads 0 while reset is applied.
    assign req_ready = (state == IDLE) && rst_done;
    assign req_hs    = bus.recv_req_valid && req_ready;
    assign m_hs      = m_tvalid_q && bus.m_tready;
    assign s_hs      = bus.s_tvalid && s_tready;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state     <= IDLE;
            ret_state <= IDLE;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ret_state_nxt = ret_state;
        s_tready      = 1'b0;
        p_tvalid      = 1'b0;
        latch_req     = 1'b0;
        latch_env     = 1'b0;
        beat_inc      = 1'b0;
        done_fire     = 1'b0;
        done_err      = 1'b0;
        m_load        = 1'b0;
        m_tail        = 1'b0;
        m_type        = 8'h00;
        m_size        = 16'h0000;

        case (state)
            IDLE: begin
                if (req_hs) begin
                    latch_req = 1'b1;
                    state_nxt = WAIT_ENV;
                end
            end

            WAIT_ENV: begin
                s_tready = 1'b1;
                if (bus.s_tvalid) begin
                    if (env_match) begin
                        latch_env = 1'b1;
                        if (!bus.s_tlast) begin
                            state_nxt = ENV_TAIL;
                        end else if (env_oversize) begin
                            state_nxt = ERR_HDR;
                            m_load    = 1'b1;
                            m_type    = T_RECV_ERROR;
                            m_size    = max_size;
                        end else begin
                            state_nxt = CTS_HDR;
                            m_load    = 1'b1;
                            m_type    = T_CLR2SND;
                            m_size    = hdr_size;
                        end
                    end else if (!bus.s_tlast) begin
                        ret_state_nxt = WAIT_ENV;
                        state_nxt     = DROP;
                    end
                end
            end

            ENV_TAIL: begin
                s_tready = 1'b1;
                if (bus.s_tvalid && bus.s_tlast) begin
                    m_load = 1'b1;
                    if (size_err) begin
                        state_nxt = ERR_HDR;
                        m_type    = T_RECV_ERROR;
                        m_size    = max_size;
                    end else begin
                        state_nxt = CTS_HDR;
                        m_type    = T_CLR2SND;
                        m_size    = env_size;
                    end
                end
            end

            CTS_HDR: begin
                if (m_hs) begin
                    state_nxt = CTS_TAIL;
                    m_load    = 1'b1;
                    m_tail    = 1'b1;
                end
            end

            CTS_TAIL: begin
                if (m_hs) state_nxt = WAIT_DATA;
            end

            WAIT_DATA: begin
                s_tready = 1'b1;
                if (bus.s_tvalid) begin
                    if (data_match) begin
                        if (bus.s_tlast) begin
                            state_nxt = DONE_HDR;
                            m_load    = 1'b1;
                            m_type    = T_DONE;
                        end else begin
                            state_nxt = PAYLOAD;
                        end
                    end else if (!bus.s_tlast) begin
                        ret_state_nxt = WAIT_DATA;
                        state_nxt     = DROP;
                    end
                end
            end

            PAYLOAD: begin
                s_tready = bus.p_tready;
                p_tvalid = bus.s_tvalid;
                beat_inc = bus.s_tvalid && bus.p_tready;
                if (bus.s_tvalid && bus.p_tready && bus.s_tlast) begin
                    state_nxt = DONE_HDR;
                    m_load    = 1'b1;
                    m_type    = T_DONE;
                end
            end

            DONE_HDR: begin
                if (m_hs) begin
                    state_nxt = DONE_TAIL;
                    m_load    = 1'b1;
                    m_tail    = 1'b1;
                end
            end

            DONE_TAIL: begin
                if (m_hs) begin
                    state_nxt = IDLE;
                    done_fire = 1'b1;
                end
            end

            ERR_HDR: begin
                if (m_hs) begin
                    state_nxt = ERR_TAIL;
                    m_load    = 1'b1;
                    m_tail    = 1'b1;
                end
            end

            ERR_TAIL: begin
                if (m_hs) begin
                    state_nxt = IDLE;
                    done_fire = 1'b1;
                    done_err  = 1'b1;
                end
            end

            DROP: begin
                s_tready = 1'b1;
                if (bus.s_tvalid && bus.s_tlast) state_nxt = ret_state;
            end

            default: state_nxt = IDLE;
        endcase
    end

    // Transfer context and completion reporting.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            peer          <= 8'h00;
            max_size      <= 16'h0000;
            env_size      <= 16'h0000;
            beat_cnt      <= 16'h0000;
            size_err      <= 1'b0;
            hdr_next      <= 1'b1;
            rst_done      <= 1'b0;
            done_valid_q  <= 1'b0;
            done_status_q <= 1'b0;
            done_beats_q  <= 16'h0000;
        end else begin
            rst_done     <= 1'b1;
            done_valid_q <= done_fire;
            if (s_hs) hdr_next <= bus.s_tlast;
            if (latch_req) begin
                peer     <= bus.recv_req_src;
                max_size <= bus.recv_req_size;
                beat_cnt <= 16'h0000;
                size_err <= 1'b0;
            end
            if (latch_env) begin
                env_size <= hdr_size;
                size_err <= env_oversize;
            end
            if (beat_inc && (beat_cnt != 16'hFFFF)) beat_cnt <= beat_cnt + 16'd1;
            if (done_fire) begin
                done_status_q <= done_err;
                done_beats_q  <= done_err ? 16'h0000 : beat_cnt;
            end
        end
    end

    // Control-packet output register; a new load wins over retiring the current beat.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= 64'd0;
            m_tlast_q  <= 1'b0;
        end else if (m_load) begin
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= m_tail;
            m_tdata_q  <= m_tail ? 64'd0
                        : {8'h01, 8'h00, m_size, m_type, bus.my_rank, 8'h00, peer};
        end else if (m_hs) begin
            m_tvalid_q <= 1'b0;
        end
    end

    assign bus.recv_req_ready   = req_ready;
    assign bus.recv_done_valid  = done_valid_q;
    assign bus.recv_done_status = done_status_q;
    assign bus.recv_done_beats  = done_beats_q;

    assign bus.s_tready = s_tready;

    assign bus.m_tvalid = m_tvalid_q;
    assign bus.m_tdata  = m_tdata_q;
    assign bus.m_tlast  = m_tlast_q;
    assign bus.m_tkeep  = 8'hFF;
    assign bus.m_tdest  = peer;

    assign bus.p_tvalid = p_tvalid;
    assign bus.p_tdata  = p_tvalid ? bus.s_tdata : 64'd0;
    assign bus.p_tkeep  = p_tvalid ? bus.s_tkeep : 8'h00;
    assign bus.p_tlast  = p_tvalid && bus.s_tlast;
endmodule
